// File: rtl/ram_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter_if
// Bundle of every bus signal around the RAM port arbiter:
//   - CPU MEM-stage requester  : cpu_req/we/addr/wdata in, cpu_ready/rvalid/
//                                rdata/stall out
//   - loader/DMA requester     : dma_req/we/addr/wdata in, dma_ready/rvalid/
//                                rdata out
//   - single-port RAM          : ram_address/write_data/wren out, ram_data in
// Modports:
//   master : the surroundings (requesters and RAM model) that drive requests
//            and RAM read data
//   slave  : the arbiter itself
// ---------------------------------------------------------------------------
interface ram_port_arbiter_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    // CPU MEM-stage side
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  cpu_ready;
    logic                  cpu_rvalid;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_stall;

    // loader/DMA side
    logic                  dma_req;
    logic                  dma_we;
    logic [ADDR_WIDTH-1:0] dma_addr;
    logic [DATA_WIDTH-1:0] dma_wdata;
    logic                  dma_ready;
    logic                  dma_rvalid;
    logic [DATA_WIDTH-1:0] dma_rdata;

    // RAM side
    logic [ADDR_WIDTH-1:0] ram_address;
    logic [DATA_WIDTH-1:0] ram_write_data;
    logic                  ram_wren;
    logic [DATA_WIDTH-1:0] ram_data;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ready, cpu_rvalid, cpu_rdata, cpu_stall,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_ready, dma_rvalid, dma_rdata,
        input  ram_address, ram_write_data, ram_wren,
        output ram_data
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ready, cpu_rvalid, cpu_rdata, cpu_stall,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_ready, dma_rvalid, dma_rdata,
        output ram_address, ram_write_data, ram_wren,
        input  ram_data
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter
// Shares one single-port synchronous RAM between the CPU MEM stage (primary)
// and a loader/DMA engine. One access is granted per cycle, combinationally:
// the CPU wins contention unless the DMA has already been refused
// STARVE_LIMIT cycles in a row, in which case the DMA gets exactly one grant.
// Read data returns one cycle after acceptance; a small owner register steers
// it to the requester that issued the read, the other port sees zero.
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous active-low reset; all outputs read 0 while low
//   bus      : ram_port_arbiter_if.slave (CPU, DMA and RAM signal groups)
// Parameters:
//   ADDR_WIDTH   : RAM address width
//   DATA_WIDTH   : data width
//   STARVE_LIMIT : consecutive DMA refusals that force a DMA grant (1..15)
// ---------------------------------------------------------------------------
module ram_port_arbiter #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    ram_port_arbiter_if.slave bus
);
    // The starvation counter is 4 bits wide, so the limit must fit in 1..15.
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    // Read-owner encoding: who receives the RAM data in the next cycle.
    localparam logic [1:0] RD_NONE = 2'd0;
    localparam logic [1:0] RD_CPU  = 2'd1;
    localparam logic [1:0] RD_DMA  = 2'd2;

    logic [3:0] starve_cnt_r;
    logic [3:0] starve_cnt_nxt_s;
    logic [1:0] rd_owner_r;
    logic [1:0] rd_owner_nxt_s;
    logic       starve_hit_s;
    logic       grant_cpu_s;
    logic       grant_dma_s;
    logic       cpu_rvalid_s;
    logic       dma_rvalid_s;

    assign starve_hit_s = (starve_cnt_r >= STARVE_MAX);

    // Fixed-priority grant with the anti-starvation override; nothing is granted in reset.
    always_comb begin
        grant_cpu_s = 1'b0;
        grant_dma_s = 1'b0;
        if (!reset_n) begin
            grant_cpu_s = 1'b0;
            grant_dma_s = 1'b0;
        end else begin
            case ({bus.cpu_req, bus.dma_req})
                2'b10: begin
                    grant_cpu_s = 1'b1;
                end
                2'b01: begin
                    grant_dma_s = 1'b1;
                end
                2'b11: begin
                    if (starve_hit_s) begin
                        grant_dma_s = 1'b1;
                    end else begin
                        grant_cpu_s = 1'b1;
                    end
                end
                default: begin
                    grant_cpu_s = 1'b0;
                    grant_dma_s = 1'b0;
                end
            endcase
        end
    end

    // Handshake outputs; ready is derived from req and grant only, never fed back.
    always_comb begin
        bus.cpu_ready = 1'b0;
        bus.dma_ready = 1'b0;
        bus.cpu_stall = 1'b0;
        if (!reset_n) begin
            bus.cpu_ready = 1'b0;
            bus.dma_ready = 1'b0;
            bus.cpu_stall = 1'b0;
        end else begin
            bus.cpu_ready = bus.cpu_req & grant_cpu_s;
            bus.dma_ready = bus.dma_req & grant_dma_s;
            bus.cpu_stall = bus.cpu_req & ~(bus.cpu_req & grant_cpu_s);
        end
    end

    // RAM drive: address/data/write-enable follow the granted requester, idle drives zero.
    always_comb begin
        bus.ram_wren       = 1'b0;
        bus.ram_address    = {ADDR_WIDTH{1'b0}};
        bus.ram_write_data = {DATA_WIDTH{1'b0}};
        if (grant_cpu_s) begin
            bus.ram_wren       = bus.cpu_we;
            bus.ram_address    = bus.cpu_addr;
            bus.ram_write_data = bus.cpu_wdata;
        end else if (grant_dma_s) begin
            bus.ram_wren       = bus.dma_we;
            bus.ram_address    = bus.dma_addr;
            bus.ram_write_data = bus.dma_wdata;
        end else begin
            bus.ram_wren       = 1'b0;
            bus.ram_address    = {ADDR_WIDTH{1'b0}};
            bus.ram_write_data = {DATA_WIDTH{1'b0}};
        end
    end

    // Next starvation count: grows (saturating) while the DMA is refused, clears otherwise.
    always_comb begin
        starve_cnt_nxt_s = 4'd0;
        if (bus.dma_req && !grant_dma_s) begin
            if (starve_hit_s) begin
                starve_cnt_nxt_s = STARVE_MAX;
            end else begin
                starve_cnt_nxt_s = starve_cnt_r + 4'd1;
            end
        end else begin
            starve_cnt_nxt_s = 4'd0;
        end
    end

    // Next read owner: only a granted read claims the next cycle's RAM data.
    always_comb begin
        rd_owner_nxt_s = RD_NONE;
        if (grant_cpu_s && !bus.cpu_we) begin
            rd_owner_nxt_s = RD_CPU;
        end else if (grant_dma_s && !bus.dma_we) begin
            rd_owner_nxt_s = RD_DMA;
        end else begin
            rd_owner_nxt_s = RD_NONE;
        end
    end

    // State registers; reset drops any read that is still in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt_r <= 4'd0;
            rd_owner_r   <= RD_NONE;
        end else begin
            starve_cnt_r <= starve_cnt_nxt_s;
            rd_owner_r   <= rd_owner_nxt_s;
        end
    end

    // Read-data steering: the non-owning port always sees zero.
    always_comb begin
        cpu_rvalid_s   = 1'b0;
        dma_rvalid_s   = 1'b0;
        bus.cpu_rvalid = 1'b0;
        bus.dma_rvalid = 1'b0;
        bus.cpu_rdata  = {DATA_WIDTH{1'b0}};
        bus.dma_rdata  = {DATA_WIDTH{1'b0}};
        if (!reset_n) begin
            cpu_rvalid_s = 1'b0;
            dma_rvalid_s = 1'b0;
        end else begin
            cpu_rvalid_s = (rd_owner_r == RD_CPU);
            dma_rvalid_s = (rd_owner_r == RD_DMA);
        end
        bus.cpu_rvalid = cpu_rvalid_s;
        bus.dma_rvalid = dma_rvalid_s;
        if (cpu_rvalid_s) begin
            bus.cpu_rdata = bus.ram_data;
        end else begin
            bus.cpu_rdata = {DATA_WIDTH{1'b0}};
        end
        if (dma_rvalid_s) begin
            bus.dma_rdata = bus.ram_data;
        end else begin
            bus.dma_rdata = {DATA_WIDTH{1'b0}};
        end
    end
endmodule
